// File: rtl/cbd_encode.sv
// Kyber CBD(eta=2) encoder: packs KYBER_N signed coefficients into the canonical sampler preimage bytes.
// Latency: 33 clk edges from the edge accepting enable to Encode_done (34 cycles start-to-start).
// Backpressure: none; enable is a start strobe sampled only in IDLE, clear aborts from any state.
module cbd_encode #(
    parameter int KYBER_N          = 256,
    parameter int i_Coeffs_Width   = 4,
    parameter int o_CharArray_Size = 1024
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              enable,
    input  logic                              clear,
    input  logic [KYBER_N*i_Coeffs_Width-1:0] iPoly,
    output logic [o_CharArray_Size-1:0]       o_CharArray,
    output logic                              Encode_done,
    output logic                              Encode_err
);

    // Eight coefficients (four output bytes) are encoded per ENC cycle.
    localparam int POLY_W    = KYBER_N * i_Coeffs_Width;
    localparam int GRP_N     = 8;
    localparam int GRP_IN_W  = GRP_N * i_Coeffs_Width;
    localparam int GRP_OUT_W = GRP_N * 4;
    localparam int NUM_GRPS  = KYBER_N / GRP_N;
    localparam int G_W       = $clog2(NUM_GRPS);
    localparam logic [G_W-1:0] G_LAST = G_W'(NUM_GRPS - 1);

    // Two's complement codes of the only legal coefficient values.
    localparam logic [i_Coeffs_Width-1:0] C_P2 = i_Coeffs_Width'(2);
    localparam logic [i_Coeffs_Width-1:0] C_P1 = i_Coeffs_Width'(1);
    localparam logic [i_Coeffs_Width-1:0] C_Z  = i_Coeffs_Width'(0);
    localparam logic [i_Coeffs_Width-1:0] C_M1 = i_Coeffs_Width'(-1);
    localparam logic [i_Coeffs_Width-1:0] C_M2 = i_Coeffs_Width'(-2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENC   = 2'd1,
        FINAL = 2'd2
    } state_t;

    state_t                    state_q;
    state_t                    state_d;
    logic                      do_start;
    logic                      do_step;
    logic                      do_final;
    logic [G_W-1:0]            g_q;

    // poly_buf shifts right one group per ENC cycle so the current group is always at the bottom;
    // work_buf shifts left so group 0 ends up in the top bytes after the last group.
    logic [POLY_W-1:0]           poly_buf;
    logic [o_CharArray_Size-1:0] work_buf;

    logic [GRP_IN_W-1:0]  grp_in;
    logic [GRP_OUT_W-1:0] grp_out;
    logic                 grp_err;

    // Canonical preimage nibble {b1,b0,a1,a0}: positive values fill a from bit 0, negative fill b.
    function automatic logic [3:0] enc_nibble(input logic [i_Coeffs_Width-1:0] c);
        logic [3:0] nib;
        nib = 4'h0;
        if (c == C_P2) begin
            nib = 4'h3;
        end else if (c == C_P1) begin
            nib = 4'h1;
        end else if (c == C_M1) begin
            nib = 4'h4;
        end else if (c == C_M2) begin
            nib = 4'hC;
        end
        return nib;
    endfunction

    // Anything outside [-2,2] cannot come from a CBD(eta=2) sampler.
    function automatic logic coeff_bad(input logic [i_Coeffs_Width-1:0] c);
        return !((c == C_P2) || (c == C_P1) || (c == C_Z) || (c == C_M1) || (c == C_M2));
    endfunction

    assign grp_in = poly_buf[GRP_IN_W-1:0];

    // Encode the current group: coefficient i goes to byte i/2 of the group (byte 0 at the top),
    // low nibble for even i, high nibble for odd i.
    always_comb begin
        grp_out = '0;
        grp_err = 1'b0;
        for (int i = 0; i < GRP_N; i++) begin
            grp_out[GRP_OUT_W - 1 - 8*(i/2) - (((i % 2) == 0) ? 4 : 0) -: 4] =
                enc_nibble(grp_in[i*i_Coeffs_Width +: i_Coeffs_Width]);
            grp_err = grp_err | coeff_bad(grp_in[i*i_Coeffs_Width +: i_Coeffs_Width]);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-edge strobes; clear overrides everything, enable only matters in IDLE.
    always_comb begin
        state_d  = state_q;
        do_start = 1'b0;
        do_step  = 1'b0;
        do_final = 1'b0;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_d  = ENC;
                        do_start = 1'b1;
                    end
                end
                ENC: begin
                    do_step = 1'b1;
                    if (g_q == G_LAST) begin
                        state_d = FINAL;
                    end
                end
                FINAL: begin
                    do_final = 1'b1;
                    state_d  = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Group counter and architecturally visible results; clear mirrors reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            g_q         <= '0;
            o_CharArray <= '0;
            Encode_done <= 1'b0;
            Encode_err  <= 1'b0;
        end else if (clear) begin
            g_q         <= '0;
            o_CharArray <= '0;
            Encode_done <= 1'b0;
            Encode_err  <= 1'b0;
        end else if (do_start) begin
            g_q         <= '0;
            Encode_done <= 1'b0;
            Encode_err  <= 1'b0;
        end else if (do_step) begin
            g_q <= g_q + G_W'(1);
            if (grp_err) begin
                Encode_err <= 1'b1;
            end
        end else if (do_final) begin
            o_CharArray <= work_buf;
            Encode_done <= 1'b1;
        end
    end

    // Datapath buffers carry no reset: their content is never observable before a start reloads them.
    always_ff @(posedge clk) begin
        if (do_start) begin
            poly_buf <= iPoly;
        end else if (do_step) begin
            poly_buf <= {{GRP_IN_W{1'b0}}, poly_buf[POLY_W-1:GRP_IN_W]};
        end
        if (do_step) begin
            work_buf <= {work_buf[o_CharArray_Size-GRP_OUT_W-1:0], grp_out};
        end
    end

endmodule

// File: tb/tb_cbd_encode.sv
// Randomised scoreboard bench for cbd_encode: stimulus pushes expectations, a monitor checks each done pulse.
// Latency: expects Encode_done 33 edges after the accepting edge.
// Backpressure: none; the bench tracks when each start is accepted and when it must complete.
module tb_cbd_encode;

    localparam int N  = 256;
    localparam int PW = 1024;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          clear;
    logic [PW-1:0] iPoly;
    logic [PW-1:0] o_CharArray;
    logic          Encode_done;
    logic          Encode_err;

    longint cyc    = 0;
    int     n_chk  = 0;
    int     n_fail = 0;

    typedef struct {
        logic [PW-1:0] poly;
        logic [PW-1:0] exp_o;
        bit            exp_err;
        longint        done_cyc;
    } exp_t;

    exp_t sb[$];

    cbd_encode #(
        .KYBER_N          (N),
        .i_Coeffs_Width   (4),
        .o_CharArray_Size (PW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .clear       (clear),
        .iPoly       (iPoly),
        .o_CharArray (o_CharArray),
        .Encode_done (Encode_done),
        .Encode_err  (Encode_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [PW-1:0] v, input int m);
        return v[PW-1-8*m -: 8];
    endfunction

    // Whole-array compare, reporting the first differing byte.
    task automatic chk_vec(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        int first;
        first = 0;
        for (int m = N/2 - 1; m >= 0; m--) begin
            if (byte_of(act, m) !== byte_of(exp, m)) first = m;
        end
        chk($sformatf("%s byte%0d", name, first), act === exp, byte_of(act, first), byte_of(exp, first));
    endtask

    function automatic int coef(input logic [PW-1:0] p, input int k);
        logic signed [3:0] c;
        c = p[4*k +: 4];
        return int'(c);
    endfunction

    // Reference: minimal-weight CBD preimage, a bits fill from bit 0 for positive, b bits from bit 2 for negative.
    task automatic model(input logic [PW-1:0] p, output logic [PW-1:0] o, output bit e);
        int         c;
        int         na;
        int         nb;
        logic [3:0] nib;
        o = '0;
        e = 1'b0;
        for (int k = 0; k < N; k++) begin
            c  = coef(p, k);
            na = 0;
            nb = 0;
            if (c > 2 || c < -2) begin
                e   = 1'b1;
                nib = 4'h0;
            end else begin
                if (c > 0) na = c; else nb = -c;
                nib = 4'(((1 << na) - 1) | (((1 << nb) - 1) << 2));
            end
            if (k % 2 == 0) o[PW-1-8*(k/2)-4 -: 4] = nib;
            else            o[PW-1-8*(k/2)   -: 4] = nib;
        end
    endtask

    // CBD(eta=2) sampler: coefficient = (a0+a1) - (b0+b1) of its nibble.
    function automatic int sample(input logic [PW-1:0] v, input int k);
        logic [7:0] b;
        logic [3:0] nib;
        b   = byte_of(v, k/2);
        nib = (k % 2 == 0) ? b[3:0] : b[7:4];
        return int'(nib[0]) + int'(nib[1]) - int'(nib[2]) - int'(nib[3]);
    endfunction

    function automatic logic [PW-1:0] rand_bits();
        logic [PW-1:0] v;
        for (int w = 0; w < PW/32; w++) v[32*w +: 32] = $urandom;
        return v;
    endfunction

    // mode 0: every coefficient in [-2,2]; mode 1: a few arbitrary 4-bit values sprinkled in.
    function automatic logic [PW-1:0] rand_poly(input int mode);
        logic [PW-1:0] v;
        int            c;
        for (int k = 0; k < N; k++) begin
            c = int'($urandom_range(4, 0)) - 2;
            v[4*k +: 4] = 4'(c);
        end
        if (mode == 1) begin
            for (int j = 0; j < 3; j++) v[4*$urandom_range(N-1, 0) +: 4] = 4'($urandom);
        end
        return v;
    endfunction

    // One start strobe; noisy runs wiggle enable and iPoly while the block is busy.
    task automatic start_run(input logic [PW-1:0] p, input logic [PW-1:0] eo, input bit ee, input bit noisy);
        exp_t e;
        @(negedge clk);
        iPoly  = p;
        enable = 1'b1;
        e.poly = p; e.exp_o = eo; e.exp_err = ee; e.done_cyc = cyc + 34;
        sb.push_back(e);
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            if (noisy) begin
                enable = 1'($urandom);
                iPoly  = rand_bits();
            end else begin
                enable = 1'b0;
            end
        end
        @(negedge clk);
        enable = 1'b0;
    endtask

    // Monitor: every rising Encode_done consumes one expectation.
    initial begin : monitor
        exp_t e;
        bit   prev;
        int   nbad;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && Encode_done === 1'b1 && !prev) begin
                chk("unexpected_done", sb.size() != 0, 64'(Encode_done), 64'(sb.size()));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("done_latency_cycle", cyc == e.done_cyc, cyc, e.done_cyc);
                    chk_vec("o_CharArray", o_CharArray, e.exp_o);
                    chk("Encode_err", Encode_err === e.exp_err, 64'(Encode_err), 64'(e.exp_err));
                    nbad = 0;
                    for (int k = 0; k < N; k++) begin
                        if (coef(e.poly, k) >= -2 && coef(e.poly, k) <= 2 &&
                            sample(o_CharArray, k) != coef(e.poly, k)) nbad++;
                    end
                    chk("cbd_sample_mismatches", nbad == 0, nbad, 0);
                end
            end
            prev = (Encode_done === 1'b1);
        end
    end

    initial begin : stimulus
        logic [PW-1:0] p;
        logic [PW-1:0] p2;
        logic [PW-1:0] eo;
        logic [PW-1:0] eo2;
        bit            ee;
        bit            ee2;
        exp_t          e;

        reset_n = 1'b0;
        enable  = 1'b0;
        clear   = 1'b0;
        iPoly   = '0;
        repeat (3) @(negedge clk);
        chk_vec("reset o_CharArray", o_CharArray, '0);
        chk("reset Encode_done", Encode_done === 1'b0, 64'(Encode_done), 0);
        chk("reset Encode_err", Encode_err === 1'b0, 64'(Encode_err), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // All-zero polynomial.
        start_run('0, '0, 1'b0, 1'b0);

        // coeff0=+2, coeff1=-1 -> byte0 = 43.
        p = '0; p[3:0] = 4'h2; p[7:4] = 4'hF;
        eo = '0; eo[PW-1 -: 8] = 8'h43;
        start_run(p, eo, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("hold Encode_done", Encode_done === 1'b1, 64'(Encode_done), 1);
        chk_vec("hold o_CharArray", o_CharArray, eo);

        // coeff255=-2, coeff254=+1 -> byte127 = C1.
        p = '0; p[PW-1 -: 4] = 4'hE; p[PW-5 -: 4] = 4'h1;
        eo = '0; eo[7:0] = 8'hC1;
        start_run(p, eo, 1'b0, 1'b0);

        // coeff100=+3 with the rest +1: error flagged, offending nibble encoded as 0.
        p = {N{4'h1}}; p[4*100 +: 4] = 4'h3;
        eo = {(N/2){8'h11}}; eo[PW-1-8*50 -: 8] = 8'h10;
        start_run(p, eo, 1'b1, 1'b0);

        // Abort with clear once g=15, then a clean restart.
        @(negedge clk);
        p = rand_poly(0); p[3:0] = 4'h7;
        iPoly  = p;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (15) @(negedge clk);
        chk("done_low_mid_run", Encode_done === 1'b0, 64'(Encode_done), 0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk_vec("clear o_CharArray", o_CharArray, '0);
        chk("clear Encode_done", Encode_done === 1'b0, 64'(Encode_done), 0);
        chk("clear Encode_err", Encode_err === 1'b0, 64'(Encode_err), 0);
        p = rand_poly(0);
        model(p, eo, ee);
        start_run(p, eo, ee, 1'b0);

        // enable held high: back-to-back runs, Encode_done a single-cycle pulse between them.
        p  = rand_poly(0); model(p, eo, ee);
        p2 = rand_poly(1); model(p2, eo2, ee2);
        @(negedge clk);
        iPoly = p; enable = 1'b1;
        e.poly = p; e.exp_o = eo; e.exp_err = ee; e.done_cyc = cyc + 34;
        sb.push_back(e);
        @(negedge clk);
        iPoly = p2;
        e.poly = p2; e.exp_o = eo2; e.exp_err = ee2; e.done_cyc = cyc + 67;
        sb.push_back(e);
        repeat (34) @(negedge clk);
        chk("done_pulse_width", Encode_done === 1'b0, 64'(Encode_done), 0);
        enable = 1'b0;
        repeat (34) @(negedge clk);

        // Asynchronous reset mid-run, away from any clock edge.
        @(negedge clk);
        iPoly = rand_poly(0); enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk_vec("async_reset o_CharArray", o_CharArray, '0);
        chk("async_reset Encode_done", Encode_done === 1'b0, 64'(Encode_done), 0);
        chk("async_reset Encode_err", Encode_err === 1'b0, 64'(Encode_err), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Random in-range polynomials, every fourth with noise on enable/iPoly while busy.
        for (int it = 0; it < 1000; it++) begin
            p = rand_poly(0);
            model(p, eo, ee);
            start_run(p, eo, ee, (it % 4) == 0);
        end

        // Random polynomials with out-of-range coefficients.
        for (int it = 0; it < 30; it++) begin
            p = rand_poly(1);
            model(p, eo, ee);
            start_run(p, eo, ee, (it % 2) == 0);
        end

        // Drain with a bounded wait; anything left never completed.
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk("missing_done", 1'b0 == 1'b1 && sb.size() > 0, 64'(Encode_done), e.done_cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cbd_encode.md
CBD_ENCODE -- requirements
Module: cbd_encode

Interface
REQ-001 SHALL have parameter KYBER_N, default 256, number of polynomial coefficients.
REQ-002 SHALL have parameter i_Coeffs_Width, default 4, width of each signed input coefficient.
REQ-003 SHALL have parameter o_CharArray_Size, default 1024, output byte-array width in bits (128 bytes).
REQ-004 SHALL have port clk, input, 1 bit, single clock; all logic rising-edge.
REQ-005 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1 bit, start request, sampled only in IDLE.
REQ-007 SHALL have port clear, input, 1 bit, synchronous abort: returns to the reset state on the next edge.
REQ-008 SHALL have port iPoly, input, 1024 bits; coefficient k is two's complement in iPoly[4k+3:4k].
REQ-009 SHALL have port o_CharArray, output reg, 1024 bits; byte 0 is o_CharArray[1023:1016], byte m is o_CharArray[1023-8m -: 8].
REQ-010 SHALL have port Encode_done, output reg, 1 bit, result valid.
REQ-011 SHALL have port Encode_err, output reg, 1 bit, at least one coefficient outside [-2,2].

Function
REQ-012 SHALL produce a canonical CBD(eta=2) preimage, so that sampling o_CharArray with the team's CBD sampler reproduces every in-range coefficient.
REQ-013 SHALL place coefficient k in byte k/2: low nibble for even k, high nibble for odd k.
REQ-014 SHALL encode the nibble as {b1,b0,a1,a0}, with the coefficient equal to (a1+a0)-(b1+b0).
REQ-015 SHALL map coefficients to nibbles as follows: +2->4'h3, +1->4'h1, 0->4'h0, -1->4'h4, -2->4'hC.
REQ-016 SHALL encode any coefficient in {-8..-3, +3..+7} as nibble 4'h0 and set the sticky Encode_err.
REQ-017 SHALL implement FSM states IDLE, ENC, FINAL.
REQ-018 SHALL take transition IDLE->ENC when enable=1 at the edge, with these same-edge actions:
- capture iPoly into an internal buffer;
- clear group counter g to 0;
- clear Encode_done and Encode_err to 0.
REQ-019 SHALL process one group per cycle in ENC: encode coefficients 8g..8g+7 into working bytes 4g..4g+3, then g<=g+1.
REQ-020 SHALL take transition ENC->FINAL on the edge that processes g=31; g SHALL be 5 bits and wrap to 0.
REQ-021 SHALL take transition FINAL->IDLE with these same-edge actions:
- load o_CharArray from the working buffer;
- set Encode_done to 1.
REQ-022 SHALL give a latency of 33 edges from the edge sampling enable to the edge setting Encode_done, for 34 cycles start-to-start.
REQ-023 SHALL ignore enable in ENC and FINAL, and SHALL NOT re-sample iPoly mid-operation.
REQ-024 SHALL hold o_CharArray, Encode_done and Encode_err in IDLE until the next accepted start or clear.
REQ-025 SHALL, while enable is held high in IDLE, restart on the edge after FINAL; Encode_done then pulses for one cycle.
REQ-026 SHALL give clear priority over enable when both are high.

Reset
REQ-027 SHALL, on reset_n low, asynchronously force the following, with no partial o_CharArray update:
- state to IDLE;
- g to 0;
- o_CharArray to 0;
- Encode_done and Encode_err to 0.
REQ-028 SHALL make clear=1 at an edge produce the same values as reset, in any state including mid-ENC.
REQ-029 SHALL leave the internal buffers unspecified after reset; they are unobservable.

Verification
REQ-030 SHALL cover: all coefficients 0, enable one cycle -> after 33 edges Encode_done=1, o_CharArray=0, Encode_err=0.
REQ-031 SHALL cover: coeff0=+2, coeff1=-1, rest 0 -> byte0=8'h43, all other bytes 0, Encode_err=0.
REQ-032 SHALL cover: coeff255=-2, coeff254=+1, rest 0 -> byte127=8'hC1 (o_CharArray[7:0]).
REQ-033 SHALL cover: coeff100=+3 (nibble 4'h3), rest +1 -> Encode_err=1, byte50=8'h10, all other bytes 8'h11.
REQ-034 SHALL cover: clear at g=15, then restart -> Encode_done low during the run; second run completes in 33 edges with the correct result.
REQ-035 SHALL cover: random in-range polynomial -> encode, sample with the CBD sampler -> identical polynomial; 1000 iterations.
